// File: rtl/somador_serial_param.sv
// Bit-serial add/subtract unit with accumulator and start/busy/done handshake.
// Optional decimal seven-segment decoder enabled by SOMADOR_SEG_DECIMAL_EN.
module somador_serial_param #(
  parameter int NBITS = 3
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             acc,
  input  logic             signed_mode,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [7:0]       seg
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] opa_q, opb_q, work_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, op_q, mode_q, carry_q, ovf_q;
  logic             sum_bit, c_next, last_bit;
  logic [NBITS-1:0] work_next;

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ c_q;
  assign c_next    = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
  assign last_bit  = (cnt_q == CW'(NBITS - 1));
  assign work_next = {sum_bit, work_q[NBITS-1:1]};

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      op_q     <= 1'b0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q  <= acc ? result_q : a;
            opb_q  <= b ^ {NBITS{op}};
            work_q <= '0;
            c_q    <= op;
            cnt_q  <= '0;
            op_q   <= op;
            mode_q <= signed_mode;
          end
        end
        SHIFT: begin
          work_q <= work_next;
          opa_q  <= opa_q >> 1;
          opb_q  <= opb_q >> 1;
          c_q    <= c_next;
          cnt_q  <= cnt_q + CW'(1);
          // Commit on the final bit edge so outputs are already valid while done is high.
          if (last_bit) begin
            result_q <= work_next;
            carry_q  <= c_next;
            ovf_q    <= mode_q ? (c_q ^ c_next) : (op_q ? ~c_next : c_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

`ifdef SOMADOR_SEG_DECIMAL_EN
  logic           res_signed_q;
  logic           neg;
  logic [NBITS:0] ext, mag;
  logic [3:0]     digit;
  logic [6:0]     glyph;

  // Display mode follows the committed result, not an operation still in flight.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      res_signed_q <= 1'b0;
    end else if (state_q == SHIFT && last_bit) begin
      res_signed_q <= mode_q;
    end
  end

  always_comb begin
    neg   = res_signed_q & result_q[NBITS-1];
    ext   = {neg, result_q};
    mag   = neg ? (~ext + (NBITS+1)'(1)) : ext;
    digit = 4'(mag);
    glyph = 7'h40;
    if (mag <= (NBITS+1)'(9)) begin
      case (digit)
        4'd0:    glyph = 7'h3F;
        4'd1:    glyph = 7'h06;
        4'd2:    glyph = 7'h5B;
        4'd3:    glyph = 7'h4F;
        4'd4:    glyph = 7'h66;
        4'd5:    glyph = 7'h6D;
        4'd6:    glyph = 7'h7D;
        4'd7:    glyph = 7'h07;
        4'd8:    glyph = 7'h7F;
        4'd9:    glyph = 7'h6F;
        default: glyph = 7'h40;
      endcase
    end
    seg = {neg, glyph};
  end
`else
  assign seg = 8'h00;
`endif

endmodule

// File: tb/tb_somador_serial_param.sv
// Directed bench for somador_serial_param with NBITS=3; seg expectations
// follow SOMADOR_SEG_DECIMAL_EN (all-zero when the decoder is compiled out).
module tb_somador_serial_param;

  logic       clk_2, reset, start, op, acc, signed_mode;
  logic [2:0] a, b;
  logic       busy, done, carry, overflow;
  logic [2:0] result;
  logic [7:0] seg;

  int tests  = 0;
  int failed = 0;
  int extra_done;

  somador_serial_param #(.NBITS(3)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .acc         (acc),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry       (carry),
    .overflow    (overflow),
    .seg         (seg)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  function automatic logic [7:0] segx(input logic [7:0] s);
`ifdef SOMADOR_SEG_DECIMAL_EN
    return s;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_2);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] ai, input logic [2:0] bi,
                        input logic opi, input logic acci, input logic smi, input logic holdi,
                        input logic [2:0] prev, input logic [2:0] er, input logic ec,
                        input logic eo, input logic [7:0] es);
    a = ai; b = bi; op = opi; acc = acci; signed_mode = smi; start = 1'b1;
    tick;                              // start sampled (edge k)
    start = holdi;
    a = ~ai; b = ~bi; op = ~opi; acc = ~acci; signed_mode = ~smi;
    chk({tag, " busy_k1"}, busy, 1);
    chk({tag, " done_k1"}, done, 0);
    tick; tick;                        // cycle k+3, last shift
    chk({tag, " done_k3"}, done, 0);
    chk({tag, " held_k3"}, result, prev);
    tick;                              // cycle k+4, DONE
    chk({tag, " done_k4"}, done, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, carry, ec);
    chk({tag, " overflow"}, overflow, eo);
    chk({tag, " seg"}, seg, segx(es));
    tick;                              // cycle k+5, IDLE
    start = 1'b0;
    chk({tag, " busy_k5"}, busy, 0);
    chk({tag, " done_k5"}, done, 0);
    $display("[TB] %s a=%0d b=%0d op=%0d acc=%0d sm=%0d -> result=%0d carry=%0d ovf=%0d seg=%02h",
             tag, ai, bi, opi, acci, smi, result, carry, overflow, seg);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; acc = 1'b0; signed_mode = 1'b0;
    a = 3'd0; b = 3'd0;
    tick; tick;
    reset = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst carry", carry, 0);
    chk("rst overflow", overflow, 0);
    chk("rst seg", seg, segx(8'h3F));
    $display("[TB] reset busy=%0d done=%0d result=%0d seg=%02h", busy, done, result, seg);

    run_op("uadd",    3'd3, 3'd2, 0, 0, 0, 0, 3'd0, 3'd5, 0, 0, 8'h6D);
    run_op("uwrap",   3'd7, 3'd1, 0, 0, 0, 0, 3'd5, 3'd0, 1, 1, 8'h3F);
    run_op("usub",    3'd5, 3'd2, 1, 0, 0, 0, 3'd0, 3'd3, 1, 0, 8'h4F);
    run_op("uborrow", 3'd2, 3'd5, 1, 0, 0, 0, 3'd3, 3'd5, 0, 1, 8'h6D);
    run_op("sovf",    3'd3, 3'd1, 0, 0, 1, 0, 3'd5, 3'd4, 0, 1, 8'hE6);
    run_op("ssub",    3'd1, 3'd3, 1, 0, 1, 0, 3'd4, 3'd6, 0, 0, 8'hDB);

    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2 result", result, 0);
    chk("rst2 seg", seg, segx(8'h3F));

    run_op("acc1", 3'd7, 3'd2, 0, 1, 0, 1, 3'd0, 3'd2, 0, 0, 8'h5B);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) extra_done++;
    end
    chk("acc1 extra_done", extra_done, 0);
    chk("acc1 idle", busy, 0);
    run_op("acc2", 3'd0, 3'd2, 0, 1, 0, 0, 3'd2, 3'd4, 0, 0, 8'h66);
    run_op("acc3", 3'd0, 3'd2, 0, 1, 0, 0, 3'd4, 3'd6, 0, 0, 8'h7D);

    a = 3'd3; b = 3'd2; op = 1'b0; acc = 1'b0; signed_mode = 1'b0; start = 1'b1;
    tick;                              // start sampled
    start = 1'b0;
    tick;                              // now in 2nd shift cycle
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort carry", carry, 0);
    chk("abort seg", seg, segx(8'h3F));
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) extra_done++;
    end
    chk("abort no_done", extra_done, 0);
    $display("[TB] abort busy=%0d result=%0d seg=%02h", busy, result, seg);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
